// File: rtl/phase_addr_gen.sv
// Phase-accumulator address generator for the sine ROM stage.
// It produces two cycle-aligned addresses (primary and phase-offset) and supports continuous and burst modes.
module phase_addr_gen #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned FRAC_WIDTH    = 8,
  parameter int unsigned BURST_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] incr,
  input  logic [ADDRESS_WIDTH-1:0]            offset,
  input  logic                                mode,
  input  logic                                start,
  input  logic                                stop,
  input  logic [BURST_WIDTH-1:0]              burst_len,
  output logic [ADDRESS_WIDTH-1:0]            addr1,
  output logic [ADDRESS_WIDTH-1:0]            addr2,
  output logic                                wrap,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned ACC_W = ADDRESS_WIDTH + FRAC_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [ACC_W-1:0]         r_acc, w_acc_nxt, w_sum;
  logic                     w_carry;
  logic [BURST_WIDTH-1:0]   r_wcnt, w_wcnt_nxt, w_wcnt_inc, w_wcnt_sat;
  logic [BURST_WIDTH-1:0]   r_blen, w_blen_nxt;
  logic                     r_mode, w_mode_nxt;
  logic                     w_wrap_nxt;
  logic [ADDRESS_WIDTH-1:0] w_addr1_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr1, r_addr2;
  logic                     r_wrap, r_busy, r_done;

  // Accumulator sum; the carry out of the MSB marks a period wrap.
  assign {w_carry, w_sum} = (ACC_W+1)'(r_acc) + (ACC_W+1)'(incr);
  assign w_wcnt_inc       = r_wcnt + BURST_WIDTH'(1);
  assign w_wcnt_sat       = (&r_wcnt) ? r_wcnt : w_wcnt_inc;
  assign w_addr1_nxt      = w_acc_nxt[ACC_W-1 -: ADDRESS_WIDTH];

  // Next-state and next-accumulator logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_wcnt_nxt  = r_wcnt;
    w_mode_nxt  = r_mode;
    w_blen_nxt  = r_blen;
    w_wrap_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_acc_nxt   = '0;
          w_wcnt_nxt  = '0;
          w_mode_nxt  = mode;
          w_blen_nxt  = burst_len;
          w_state_nxt = (mode && (burst_len == '0)) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_FINISH;
        end else if (en) begin
          w_acc_nxt = w_sum;
          if (w_carry) begin
            w_wrap_nxt = 1'b1;
            w_wcnt_nxt = w_wcnt_sat;
            // The final accumulate still commits, so FINISH shows the wrapped address.
            if (r_mode && (w_wcnt_inc == r_blen)) begin
              w_state_nxt = ST_FINISH;
            end
          end
        end
      end
      ST_FINISH: begin
        w_acc_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_acc_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, all derived from the same next values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_wcnt  <= '0;
      r_mode  <= 1'b0;
      r_blen  <= '0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_mode  <= w_mode_nxt;
      r_blen  <= w_blen_nxt;
      r_addr1 <= w_addr1_nxt;
      r_addr2 <= w_addr1_nxt + offset;
      r_wrap  <= w_wrap_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_FINISH);
    end
  end

  assign addr1 = r_addr1;
  assign addr2 = r_addr2;
  assign wrap  = r_wrap;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_phase_addr_gen.sv
// Bench for phase_addr_gen: directed scenarios plus random traffic.
// Every cycle's outputs are checked against a cycle-level behavioural model.
module tb_phase_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, start, stop;
  logic [15:0] incr;
  logic [7:0]  offset, burst_len;
  logic [7:0]  addr1, addr2;
  logic        wrap, busy, done;

  int total = 0;
  int bad   = 0;
  int n_wrap = 0;
  int n_done = 0;

  // Model: 0 idle, 1 running, 2 finishing
  int m_st = 0;
  int m_phase = 0;
  int m_wraps = 0;
  int m_burst = 0;
  int m_len = 0;
  int e_addr1 = 0, e_addr2 = 0, e_wrap = 0, e_busy = 0, e_done = 0;

  phase_addr_gen #(.ADDRESS_WIDTH(8), .FRAC_WIDTH(8), .BURST_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .incr(incr), .offset(offset),
    .mode(mode), .start(start), .stop(stop), .burst_len(burst_len),
    .addr1(addr1), .addr2(addr2), .wrap(wrap), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Predict the outputs after the coming clock edge from the inputs now applied.
  task automatic model_edge();
    int s;
    e_wrap = 0;
    if (!rst_n) begin
      m_st = 0; m_phase = 0; m_wraps = 0;
    end else if (m_st == 2) begin
      m_st = 0; m_phase = 0;
    end else if (m_st == 1) begin
      if (stop) m_st = 2;
      else if (en) begin
        s = m_phase + int'(incr);
        m_phase = s % 65536;
        if (s >= 65536) begin
          e_wrap = 1;
          if (m_wraps < 255) m_wraps++;
          if (m_burst == 1 && m_wraps == m_len) m_st = 2;
        end
      end
    end else if (start) begin
      m_phase = 0; m_wraps = 0;
      m_burst = int'(mode); m_len = int'(burst_len);
      m_st = (m_burst == 1 && m_len == 0) ? 2 : 1;
    end
    e_addr1 = m_phase / 256;
    e_addr2 = rst_n ? (e_addr1 + int'(offset)) % 256 : 0;
    e_busy  = (m_st == 1) ? 1 : 0;
    e_done  = (m_st == 2) ? 1 : 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("addr1", 32'(addr1), 32'(e_addr1));
    check("addr2", 32'(addr2), 32'(e_addr2));
    check("wrap",  32'(wrap),  32'(e_wrap));
    check("busy",  32'(busy),  32'(e_busy));
    check("done",  32'(done),  32'(e_done));
    if (wrap === 1'b1) n_wrap++;
    if (done === 1'b1) n_done++;
  endtask

  initial begin
    // Reset dominates start/en
    rst_n = 1'b0; start = 1'b1; en = 1'b1; stop = 1'b0; mode = 1'b0;
    incr = 16'h0100; offset = 8'h40; burst_len = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1; start = 1'b0;
    tick();

    // Continuous integer step: exactly one wrap per 256 steps
    start = 1'b1; tick(); start = 1'b0;
    n_wrap = 0;
    repeat (260) tick();
    check("cont_wraps", 32'(n_wrap), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // Fractional step with an en-low freeze
    incr = 16'h0080; offset = 8'hF0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    en = 1'b0; repeat (3) tick(); en = 1'b1;
    repeat (6) tick();
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // Burst of two periods
    mode = 1'b1; burst_len = 8'd2; incr = 16'h8000;
    start = 1'b1; tick(); start = 1'b0; mode = 1'b0; burst_len = 8'd9;
    n_done = 0; n_wrap = 0;
    repeat (6) tick();
    check("burst_done_cnt", 32'(n_done), 32'd1);
    check("burst_wrap_cnt", 32'(n_wrap), 32'd2);

    // stop mid-RUN, with a start during RUN ignored
    mode = 1'b0; incr = 16'h0300;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    n_done = 0;
    stop = 1'b1; tick(); stop = 1'b0; repeat (2) tick();
    check("stop_done_cnt", 32'(n_done), 32'd1);

    // stop coincident with final burst wrap
    mode = 1'b1; burst_len = 8'd1; incr = 16'h8000;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_done = 0; n_wrap = 0;
    stop = 1'b1; tick(); stop = 1'b0; repeat (2) tick();
    check("coinc_done_cnt", 32'(n_done), 32'd1);
    check("coinc_wrap_cnt", 32'(n_wrap), 32'd0);

    // Zero-length burst goes straight to FINISH
    burst_len = 8'd0; n_done = 0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    check("zero_burst_done", 32'(n_done), 32'd1);

    // Reset mid-burst
    burst_len = 8'd5; incr = 16'h4000;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (2) tick();

    // Random traffic
    repeat (2000) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      burst_len = 8'($urandom_range(0, 4));
      offset    = 8'($urandom);
      if ($urandom_range(0, 15) == 0)
        incr = 16'h0000;
      else if ($urandom_range(0, 1) == 0)
        incr = 16'($urandom);
      else
        incr = 16'($urandom_range(16'h2000, 16'hFFFF));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_addr_gen.md
Name: phase_addr_gen

Overview:
Phase-accumulator address generator that drives the address inputs of the sine lookup ROM stage. It produces a primary address and a second address offset by a programmable phase, for dual-channel waveform output. It supports continuous running and burst mode; burst mode stops after a set number of waveform periods. The outputs are registered, so the ROM's one-cycle read latency is the only remaining pipeline delay.

Parameters:
ADDRESS_WIDTH, 8, ROM address width; integer part of the phase accumulator.
FRAC_WIDTH, 8, fractional bits of the phase accumulator, used for sub-unit frequency steps.
BURST_WIDTH, 8, width of the burst period count.

Ports:
clk  input  1  single system clock; all logic on posedge.
rst_n  input  1  synchronous, active-low reset.
en  input  1  advance enable; when low in RUN, the accumulator holds.
incr  input  ADDRESS_WIDTH+FRAC_WIDTH  phase step per enabled cycle; sampled live every cycle.
offset  input  ADDRESS_WIDTH  phase offset for addr2; sampled live.
mode  input  1  0 = continuous, 1 = burst; sampled on start.
start  input  1  begin generation; honoured only in IDLE.
stop  input  1  abort generation; honoured only in RUN.
burst_len  input  BURST_WIDTH  number of periods (wraps) in burst mode; sampled on start.
addr1  output  ADDRESS_WIDTH  primary ROM address = acc[MSB -: ADDRESS_WIDTH].
addr2  output  ADDRESS_WIDTH  secondary ROM address = addr1 + offset, mod 2^ADDRESS_WIDTH.
wrap  output  1  one-cycle pulse when addr1 has just wrapped through zero.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse in FINISH.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, acc=0, wrap count=0, addr1=0, addr2=0, wrap=0, busy=0, done=0. Reset overrides every other input, including mid-RUN.
- Accumulator width is ADDRESS_WIDTH+FRAC_WIDTH. Addition is modulo 2^(ADDRESS_WIDTH+FRAC_WIDTH). The carry out of the MSB defines a wrap.
- addr1 and addr2 are both registered from the same next-accumulator value, so they are always cycle-aligned.
- addr2 tracks offset changes with one cycle of latency in every state.
- FSM IDLE:
  - acc held; busy=0.
  - When start=1: acc<=0, wrap count<=0, latch mode and burst_len.
  - If burst mode and burst_len=0, go directly to FINISH; otherwise go to RUN.
  - stop is ignored in IDLE. If start and stop are both high, start wins.
- FSM RUN:
  - busy=1.
  - If en=1: acc<=acc+incr. On carry, wrap<=1 next cycle and wrap count increments.
  - If en=0: acc holds and wrap<=0.
  - Burst mode: when a carry occurs and wrap count+1 == latched burst_len, go to FINISH. The final accumulate still commits, so addr1 shows the wrapped value during FINISH.
  - stop=1 goes to FINISH on the next edge, with no further accumulate that cycle. stop has priority over a simultaneous final wrap; done is still produced exactly once.
  - start is ignored in RUN. incr=0 is legal: the accumulator holds, so a burst never completes without stop.
- FSM FINISH (one cycle): done=1, busy=0, acc<=0, go to IDLE. wrap may be high here only from the carry that caused FINISH.
- Continuous mode never leaves RUN except via stop or reset. The wrap count saturates and is not used in continuous mode.
- The downstream ROM adds one cycle, so ROM data corresponds to the addr1 value from the previous cycle.

Test Plan:
1. Reset with start=1, en=1 -> addr1=0, addr2=0, busy=0, done=0, wrap=0 on every cycle while rst_n=0.
2. Continuous: incr=0x0100, offset=0x40, start pulse, en=1 -> addr1 goes 0,1,2,…,255,0 and addr2 = addr1+0x40 in the same cycle. wrap is high only on the cycle addr1 returns to 0 (after 256 steps). busy stays 1.
3. Fractional step: incr=0x0080 -> addr1 = 0,0,1,1,2,2,… (one step per 2 cycles). Toggling en low for 3 cycles freezes addr1 for 3 cycles.
4. Burst: mode=1, burst_len=2, incr=0x8000 -> addr1 = 0,0x80,0x00(wrap),0x80,0x00(wrap). The FINISH cycle carries done=1; then IDLE, acc=0, busy=0.
5. stop mid-RUN and stop coincident with the final burst wrap -> FINISH the next cycle, single done pulse, addr1=0 afterwards. A start during RUN has no effect.
6. burst_len=0 with mode=1 -> IDLE to FINISH directly, done=1 one cycle after start, addr1 never leaves 0. Reset asserted mid-burst -> IDLE with all outputs 0 on the next edge.
